// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bundle for fifo_rd_ctrl: the FIFO read port plus the downstream valid/ready stream.
// Stream handshake: a word moves when out_valid & out_ready are both high at a rising clk edge.
// While out_valid is high and out_ready is low, out_data holds its value.
interface fifo_rd_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int PTR   = 4
);
  logic             rden;
  logic             rdempty;
  logic [PTR:0]     rdusedw;
  logic [WIDTH-1:0] dataout;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output rden, out_data, out_valid,
    input  rdempty, rdusedw, dataout, out_ready
  );

  modport slave (
    input  rden, out_data, out_valid,
    output rdempty, rdusedw, dataout, out_ready
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Drains a FIFO read port in bounded bursts, absorbs its 1-cycle read latency and
// presents the words through a 2-entry skid buffer with a delivered-word counter.
module fifo_rd_ctrl #(
  parameter int WIDTH  = 8,
  parameter int PTR    = 4,
  parameter int THRESH = 1,
  parameter int BURST  = 4
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          enable,
  fifo_rd_ctrl_if.master bus,
  output logic          burst_active,
  output logic [15:0]   words_out,
  output logic [1:0]    dbg_state
);

  localparam int CW = $clog2(BURST + 1);
  localparam int PW = PTR + 1;
  localparam logic [CW-1:0] BURST_MAX = CW'(BURST);
  localparam logic [PW-1:0] THRESH_W  = PW'(THRESH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    burst_cnt_q, burst_cnt_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] buf0_q, buf0_d;
  logic [WIDTH-1:0] buf1_q, buf1_d;
  logic [15:0]      words_q, words_d;

  logic [PW-1:0] inflight_w;
  logic          pop;
  logic          push;
  logic [2:0]    committed;
  logic          credit_ok;
  logic          rden_w;

  assign inflight_w = {{PTR{1'b0}}, inflight_q};
  assign pop        = (occ_q != 2'd0) & bus.out_ready;
  assign push       = inflight_q;

  // A word leaving this cycle frees its slot, which keeps a burst at one word per cycle.
  assign committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign credit_ok = committed < 3'd2;

  assign rden_w = (state_q == ST_BURST) & enable & ~bus.rdempty &
                  (bus.rdusedw > inflight_w) & credit_ok & (burst_cnt_q < BURST_MAX);

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && !bus.rdempty && (bus.rdusedw >= THRESH_W)) begin
          state_d     = ST_BURST;
          burst_cnt_d = '0;
        end
      end
      ST_BURST: begin
        if (rden_w) burst_cnt_d = burst_cnt_q + 1'b1;
        if ((burst_cnt_q == BURST_MAX) || (bus.rdusedw <= inflight_w) || !enable)
          state_d = ST_GAP;
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    occ_d      = occ_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    inflight_d = rden_w;
    words_d    = words_q + {15'd0, pop};
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = bus.dataout;
        else               buf1_d = bus.dataout;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = bus.dataout;
        end else begin
          buf0_d = buf1_q;
          buf1_d = bus.dataout;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      words_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      words_q     <= words_d;
    end
  end

  assign bus.rden      = rden_w;
  assign bus.out_data  = buf0_q;
  assign bus.out_valid = (occ_q != 2'd0);
  assign burst_active  = (state_q == ST_BURST);
  assign words_out     = words_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a lagging-flag FIFO model feeds dut, a scoreboard checks the stream;
// a second instance (THRESH=3, long bursts) covers the start threshold and words_out wrap.
module tb_fifo_rd_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_;
  logic        enable, enable2;
  logic        out_ready1, out_ready2;
  logic [4:0]  usedw2;
  logic        burst_active, burst_active2;
  logic [15:0] words_out, words_out2;
  logic [1:0]  dbg_state, dbg_state2;

  fifo_rd_ctrl_if #(.WIDTH(8), .PTR(4)) bus1 ();
  fifo_rd_ctrl_if #(.WIDTH(8), .PTR(4)) bus2 ();

  fifo_rd_ctrl #(.WIDTH(8), .PTR(4), .THRESH(1), .BURST(4)) dut (
    .clk(clk), .reset_(reset_), .enable(enable), .bus(bus1.master),
    .burst_active(burst_active), .words_out(words_out), .dbg_state(dbg_state)
  );

  fifo_rd_ctrl #(.WIDTH(8), .PTR(4), .THRESH(3), .BURST(65535)) dut2 (
    .clk(clk), .reset_(reset_), .enable(enable2), .bus(bus2.master),
    .burst_active(burst_active2), .words_out(words_out2), .dbg_state(dbg_state2)
  );

  // FIFO model: rdusedw/rdempty lag the reads by one extra cycle, like a real read port.
  logic [7:0]  fmem [16];
  int unsigned wr_total = 0;
  int unsigned rd_total = 0;
  logic [4:0]  usedw_lag = 5'd0;
  logic [7:0]  dout_r = 8'd0;

  always @(posedge clk) begin
    if (bus1.rden) begin
      dout_r   <= fmem[4'(rd_total)];
      rd_total <= rd_total + 1;
    end
    usedw_lag <= 5'(wr_total - rd_total);
  end

  assign bus1.rdusedw   = usedw_lag;
  assign bus1.rdempty   = (usedw_lag == 5'd0);
  assign bus1.dataout   = dout_r;
  assign bus1.out_ready = out_ready1;

  assign bus2.rdusedw   = usedw2;
  assign bus2.rdempty   = 1'b0;
  assign bus2.dataout   = 8'h5A;
  assign bus2.out_ready = out_ready2;

  logic [7:0] exp_q [$];
  int tests = 0;
  int fails = 0;

  // Scoreboard monitor: every accepted stream word must match the head of exp_q.
  always @(negedge clk) begin
    if (reset_ && bus1.out_valid && bus1.out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL stream_extra: got %h, expected no word", bus1.out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus1.out_data !== e) begin
          fails++;
          $display("FAIL stream_data: got %h, required %h", bus1.out_data, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] base, input int n);
    step();
    for (int i = 0; i < n; i++) begin
      fmem[4'(wr_total + i)] = base + 8'(i);
      exp_q.push_back(base + 8'(i));
    end
    wr_total += n;
  endtask

  task automatic wait_rden(input int max);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus1.rden) begin
        found = 1'b1;
        break;
      end
    end
    check("rden_seen", 32'(found), 32'd1);
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] rh, vh;
    int n;
    int hs;

    reset_ = 1'b0; enable = 1'b0; enable2 = 1'b0;
    out_ready1 = 1'b1; out_ready2 = 1'b0; usedw2 = 5'd0;

    @(negedge clk);
    check("rst_rden",      32'(bus1.rden),      32'd0);
    check("rst_out_valid", 32'(bus1.out_valid), 32'd0);
    check("rst_out_data",  32'(bus1.out_data),  32'd0);
    check("rst_burst",     32'(burst_active),   32'd0);
    check("rst_words",     32'(words_out),      32'd0);
    check("rst_state",     32'(dbg_state),      32'd0);
    step();
    reset_ = 1'b1; enable = 1'b1;

    // T1: 6 words, burst of 4, gap, burst of 2
    load(8'hA0, 6);
    wait_rden(20);
    for (int i = 0; i < 12; i++) begin
      if (i != 0) @(negedge clk);
      rh[i] = bus1.rden;
      vh[i] = bus1.out_valid;
    end
    check("t1_rden_pattern",  32'(rh), 32'(12'b000110001111));
    check("t1_valid_pattern", 32'(vh), 32'(12'b011000111100));
    check("t1_words", 32'(words_out), 32'd6);
    check("t1_queue", 32'(exp_q.size()), 32'd0);

    // T2: downstream stalled, only two reads fit, head held stable
    step();
    out_ready1 = 1'b0;
    load(8'hB0, 6);
    wait_rden(20);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge clk);
      if (bus1.rden) n++;
      if (i == 2) check("t2_head_first", 32'(bus1.out_data), 32'h0B0);
    end
    check("t2_rden_count", 32'(n), 32'd2);
    check("t2_hold_valid", 32'(bus1.out_valid), 32'd1);
    check("t2_hold_data",  32'(bus1.out_data), 32'h0B0);
    step();
    out_ready1 = 1'b1;
    wait_drain(60);
    repeat (4) @(negedge clk);
    check("t2_words", 32'(words_out), 32'd12);

    // T3: single word with lagging rdusedw/rdempty
    load(8'hC0, 1);
    wait_rden(20);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      if (bus1.rden) n++;
    end
    check("t3_rden_count", 32'(n), 32'd1);
    check("t3_words", 32'(words_out), 32'd13);

    // T5: enable dropped in the second burst cycle
    load(8'hD0, 4);
    wait_rden(20);
    step();
    enable = 1'b0;
    @(negedge clk);
    check("t5_no_rden",   32'(bus1.rden), 32'd0);
    check("t5_st_burst",  32'(dbg_state), 32'd1);
    @(negedge clk);
    check("t5_st_gap",    32'(dbg_state), 32'd2);
    @(negedge clk);
    check("t5_st_idle",   32'(dbg_state), 32'd0);
    repeat (4) @(negedge clk);
    check("t5_words", 32'(words_out), 32'd14);
    check("t5_left",  32'(exp_q.size()), 32'd3);

    // T6: async reset with the skid buffer full
    step();
    out_ready1 = 1'b0;
    enable = 1'b1;
    wait_rden(20);
    repeat (4) @(negedge clk);
    check("t6_full_valid", 32'(bus1.out_valid), 32'd1);
    check("t6_full_head",  32'(bus1.out_data), 32'h0D1);
    @(posedge clk);
    #3 reset_ = 1'b0;
    #1;
    check("t6_rst_rden",  32'(bus1.rden),      32'd0);
    check("t6_rst_valid", 32'(bus1.out_valid), 32'd0);
    check("t6_rst_words", 32'(words_out),      32'd0);
    check("t6_rst_burst", 32'(burst_active),   32'd0);
    exp_q.delete();
    wr_total = rd_total;
    step();
    step();
    reset_ = 1'b1;
    out_ready1 = 1'b1;
    @(negedge clk);
    check("t6_idle", 32'(dbg_state), 32'd0);
    load(8'hE0, 3);
    wait_drain(40);
    repeat (3) @(negedge clk);
    check("t6_words", 32'(words_out), 32'd3);

    // T4: THRESH=3 start condition on dut2
    step();
    enable2 = 1'b1;
    out_ready2 = 1'b1;
    usedw2 = 5'd2;
    repeat (4) @(negedge clk);
    check("t4_rden_low",  32'(bus2.rden),     32'd0);
    check("t4_idle",      32'(burst_active2), 32'd0);
    step();
    usedw2 = 5'd3;
    @(negedge clk);
    check("t4_not_yet",   32'(burst_active2), 32'd0);
    @(negedge clk);
    check("t4_burst",     32'(burst_active2), 32'd1);
    step();
    usedw2 = 5'd16;

    // words_out wrap: run to 0xFFFE, then deliver 3 more
    hs = 0;
    for (int k = 0; k < 70000 && hs != 65534; k++) begin
      @(negedge clk);
      if (bus2.out_valid && bus2.out_ready) hs++;
    end
    check("wrap_reached", 32'(hs), 32'd65534);
    step();
    out_ready2 = 1'b0;
    enable2 = 1'b0;
    @(negedge clk);
    check("wrap_fffe", 32'(words_out2), 32'h0FFFE);
    step();
    enable2 = 1'b1;
    out_ready2 = 1'b1;
    hs = 0;
    for (int k = 0; k < 20 && hs != 3; k++) begin
      @(negedge clk);
      if (bus2.out_valid && bus2.out_ready) hs++;
    end
    step();
    out_ready2 = 1'b0;
    @(negedge clk);
    check("wrap_0001", 32'(words_out2), 32'h00001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
